// File: rtl/rr_slot_scheduler.sv
// rtl/rr_slot_scheduler.sv - round-robin owner scheduler for one shared slot among 7 requesters.
// Optional macro RR_NOGAP_EN: hand the slot straight to the next requester on release, with no idle gap.
module rr_slot_scheduler #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       req,
  input  logic             done,
  output logic [2:0]       sel_code,
  output logic [6:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic [2:0]       sel_q, sel_nx;
  logic [2:0]       last_q, last_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [2:0]       owner;
  logic [3:0]       pick_idle;
  logic             release_now;

  // Returns {found, index}: first set bit of r searching upward from last+1, wrapping 6 -> 0.
  function automatic logic [3:0] rr_pick(input logic [6:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [3:0] res;
    res = 4'b0;
    idx = (last >= 3'd6) ? 3'd0 : last + 3'd1;
    for (int i = 0; i < 7; i++) begin
      if (!res[3] && r[idx]) res = {1'b1, idx};
      idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
    end
    return res;
  endfunction

  // owner is only meaningful while BUSY; sel_q is then 1..7.
  assign owner       = sel_q - 3'd1;
  assign pick_idle   = rr_pick(req, last_q);
  assign release_now = done || !req[owner] || (cnt_q == CNT_W'(MAX_BURST));

`ifdef RR_NOGAP_EN
  logic [3:0] pick_next;
  assign pick_next = rr_pick(req & ~(7'(1) << owner), owner);
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    last_nx  = last_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        sel_nx = 3'd0;
        cnt_nx = '0;
        if (en && pick_idle[3]) begin
          state_nx = BUSY;
          sel_nx   = pick_idle[2:0] + 3'd1;
          cnt_nx   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (release_now) begin
          last_nx  = owner;
          state_nx = IDLE;
          sel_nx   = 3'd0;
          cnt_nx   = '0;
`ifdef RR_NOGAP_EN
          if (en && pick_next[3]) begin
            state_nx = BUSY;
            sel_nx   = pick_next[2:0] + 3'd1;
            cnt_nx   = CNT_W'(1);
          end
`endif
        end else if (cnt_q != CNT_W'(MAX_BURST)) begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= 3'd0;
      last_q <= 3'd6;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      sel_q  <= sel_nx;
      last_q <= last_nx;
      cnt_q  <= cnt_nx;
    end
  end

  assign sel_code  = sel_q;
  assign grant     = (sel_q == 3'd0) ? 7'd0 : (7'(1) << owner);
  assign busy      = (state == BUSY);
  assign burst_cnt = cnt_q;

endmodule

// File: doc/rr_slot_scheduler.md
Name: rr_slot_scheduler

Overview:
- Round-robin scheduler that shares one datapath slot among 7 requesters (e.g. PE lanes contending for an aggregation bank).
- Outputs a 3-bit select code: 0 means no owner; k = 1..7 means requester k-1 owns the slot.
- Also outputs the matching one-hot grant. This is the same encoding consumed by the 3-to-8 select decoder downstream.
- Holds each grant for a bounded burst, then rotates fairly.

Parameters:
MAX_BURST, 16, maximum consecutive cycles one requester may hold the slot (1..31)
CNT_W, 5, burst counter width; must satisfy 2**CNT_W > MAX_BURST

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  scheduler enable; when 0, no new grant is issued
req  input  7  request vector; bit i is requester i, level-sensitive
done  input  1  single-cycle pulse from the current owner: release now
sel_code  output  3  registered owner code: 0 = none, i+1 = requester i
grant  output  7  registered one-hot grant; bit i set iff sel_code == i+1; all zeros when sel_code == 0
busy  output  1  high while a grant is held (sel_code != 0)
burst_cnt  output  CNT_W  cycles the current owner has held the slot, 1-based; 0 when idle

Behaviour:
- Reset (async, rst=1):
  - sel_code=0, grant=0, busy=0, burst_cnt=0.
  - state=IDLE.
  - last_owner pointer = 6, so requester 0 has first priority after reset.
- States: IDLE, BUSY.
- IDLE:
  - If en=1 and req!=0, pick the winner as the first set bit of req searching upward from (last_owner+1) mod 7, wrapping from 6 to 0.
  - Next cycle: sel_code=winner+1, grant=1<<winner, busy=1, burst_cnt=1, state=BUSY.
  - Latency from req to grant is 1 cycle.
  - If en=0 or req=0, remain IDLE with all outputs at 0.
- BUSY: release when any of the following holds for the owner in the current cycle:
  - done=1,
  - req[owner]=0,
  - burst_cnt == MAX_BURST.
- On release:
  - The next cycle has sel_code=0, grant=0, busy=0, burst_cnt=0, state=IDLE.
  - last_owner is set to the owner.
  - This gives exactly one dead cycle between owners.
- No release: burst_cnt increments by 1; the counter saturates at MAX_BURST and never wraps.
- en=0 while BUSY: the current grant continues until a normal release. en only gates new grants.
- Requests from non-owners while BUSY are ignored (not latched). They are evaluated in the IDLE cycle.
- Simultaneous release conditions are treated identically (single release).
- done while IDLE is ignored.
- Reset mid-burst: outputs clear immediately (asynchronous); the rotation pointer returns to 6.
- grant is always the decoded form of sel_code; the two never disagree in any cycle.

Optional Feature:
- Macro: RR_NOGAP_EN.
- Defined:
  - On release, if en=1 and another requester (excluding the releasing owner) is set in req that cycle, the next cycle directly grants the RR winner searched from owner+1.
  - Outputs: sel_code=winner+1, burst_cnt=1, state stays BUSY. There is no dead cycle.
  - If only the releasing owner still requests, it may be re-granted only after one IDLE cycle.
  - If no one requests, go to IDLE as normal.
- Undefined: the mandatory one-cycle IDLE gap between grants, as described above.

Test Plan:
- Reset then req=7'b0000001, en=1 -> sel_code=1, grant=7'b0000001 one cycle after req; burst_cnt counts 1,2,3…
- req=7'b1111111 held, MAX_BURST=4:
  - Base build -> owners 0,1,2…6,0 in order, each 4 cycles with sel_code=1..7, separated by 1 cycle of sel_code=0.
  - With RR_NOGAP_EN -> no zero cycles.
- Owner 3 (sel_code=4) gets done pulse at burst_cnt=2 with req=7'b0001001 -> gap cycle, then sel_code=1 (wrap to requester 0).
- Owner drops req at burst_cnt=5 -> next cycle sel_code=0, busy=0, burst_cnt=0.
- en=0 with req=7'b0100000 -> sel_code stays 0. Raise en -> sel_code=6 the next cycle. Drop en while BUSY -> grant held until MAX_BURST.
- Assert rst at burst_cnt=3 of owner 5 -> outputs 0 immediately. After release with req=7'b1111111 -> first grant is sel_code=1.
